// File: rtl/reg_adrs_sequencer_pkg.sv
// Shared encodings for the register-address sequencer: sweep modes, FSM states and parameter defaults.
package reg_adrs_sequencer_pkg;

    localparam logic [1:0] MODE_CONST = 2'b00;
    localparam logic [1:0] MODE_UP    = 2'b01;
    localparam logic [1:0] MODE_DOWN  = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int ADRS_WIDTH_DEF = 3;
    localparam int ZERO_ADRS_DEF  = 0;

    // Mode 11 is reserved and behaves as CONST, so only UP/DOWN count as sweeps.
    function automatic logic is_sweep(input logic [1:0] m);
        return (m == MODE_UP) || (m == MODE_DOWN);
    endfunction

endpackage

// File: rtl/reg_adrs_stepper.sv
// Combinational next-address, start/end-point adjustment and terminal compare for the sequencer.
// Optional macro SKIP_ZERO_EN: sweeps step over ZERO_ADRS and never land on it.
module reg_adrs_stepper
    import reg_adrs_sequencer_pkg::*;
#(
    parameter int ADRS_WIDTH = ADRS_WIDTH_DEF,
    parameter int ZERO_ADRS  = ZERO_ADRS_DEF
) (
    input  logic [1:0]            i_mode,
    input  logic [ADRS_WIDTH-1:0] i_cur,
    input  logic [ADRS_WIDTH-1:0] i_last,
    input  logic [ADRS_WIDTH-1:0] i_first_raw,
    input  logic [ADRS_WIDTH-1:0] i_last_raw,
    output logic [ADRS_WIDTH-1:0] o_next,
    output logic [ADRS_WIDTH-1:0] o_first,
    output logic [ADRS_WIDTH-1:0] o_last,
    output logic                  o_at_last
);

    localparam logic [ADRS_WIDTH-1:0] ZERO = ADRS_WIDTH'(ZERO_ADRS);
    localparam logic [ADRS_WIDTH-1:0] ONE  = ADRS_WIDTH'(1);

    logic                  w_down;
    logic [ADRS_WIDTH-1:0] w_step1;

    assign w_down    = (i_mode == MODE_DOWN);
    assign w_step1   = w_down ? (i_cur - ONE) : (i_cur + ONE);
    assign o_at_last = (i_cur == i_last);

`ifdef SKIP_ZERO_EN
    logic                  w_sweep;
    logic [ADRS_WIDTH-1:0] w_step2;
    logic [ADRS_WIDTH-1:0] w_first_step;

    assign w_sweep      = is_sweep(i_mode);
    assign w_step2      = w_down ? (w_step1 - ONE) : (w_step1 + ONE);
    assign w_first_step = w_down ? (i_first_raw - ONE) : (i_first_raw + ONE);

    always_comb begin
        o_next  = (w_step1 == ZERO) ? w_step2 : w_step1;
        o_first = i_first_raw;
        o_last  = i_last_raw;
        if (w_sweep && (i_first_raw == ZERO))
            o_first = w_first_step;
        // An end point of zero moves back to its neighbour on the approach side.
        if (w_sweep && (i_last_raw == ZERO))
            o_last = w_down ? (ZERO + ONE) : (ZERO - ONE);
    end
`else
    assign o_next  = w_step1;
    assign o_first = i_first_raw;
    assign o_last  = i_last_raw;
`endif

endmodule

// File: rtl/reg_adrs_sequencer.sv
// Register-file address source: constant address or inclusive up/down sweep, registered outputs.
// Optional macro SKIP_ZERO_EN (handled in reg_adrs_stepper) keeps sweeps off ZERO_ADRS.
module reg_adrs_sequencer
    import reg_adrs_sequencer_pkg::*;
#(
    parameter int ADRS_WIDTH = ADRS_WIDTH_DEF,
    parameter int ZERO_ADRS  = ZERO_ADRS_DEF
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [ADRS_WIDTH-1:0] firstAdrs,
    input  logic [ADRS_WIDTH-1:0] lastAdrs,
    input  logic                  stall,
    output logic [ADRS_WIDTH-1:0] adrsOut,
    output logic                  adrsValid,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADRS_WIDTH-1:0] ZERO = ADRS_WIDTH'(ZERO_ADRS);

    logic [1:0]            r_state;
    logic [1:0]            r_mode;
    logic [ADRS_WIDTH-1:0] r_last;
    logic [ADRS_WIDTH-1:0] r_adrs;
    logic                  r_valid;
    logic                  r_busy;
    logic                  r_done;

    logic [1:0]            w_mode;
    logic [ADRS_WIDTH-1:0] w_next;
    logic [ADRS_WIDTH-1:0] w_first;
    logic [ADRS_WIDTH-1:0] w_last;
    logic                  w_at_last;

    // The stepper sees the live mode while idle (to adjust end points) and the latched one while running.
    assign w_mode = (r_state == ST_IDLE) ? mode : r_mode;

    reg_adrs_stepper #(
        .ADRS_WIDTH (ADRS_WIDTH),
        .ZERO_ADRS  (ZERO_ADRS)
    ) u_stepper (
        .i_mode      (w_mode),
        .i_cur       (r_adrs),
        .i_last      (r_last),
        .i_first_raw (firstAdrs),
        .i_last_raw  (lastAdrs),
        .o_next      (w_next),
        .o_first     (w_first),
        .o_last      (w_last),
        .o_at_last   (w_at_last)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_CONST;
            r_last  <= ZERO;
            r_adrs  <= ZERO;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_mode  <= mode;
                        r_last  <= w_last;
                        r_adrs  <= w_first;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!stall) begin
                        if (!is_sweep(r_mode) || w_at_last) begin
                            r_state <= ST_DONE;
                            r_adrs  <= ZERO;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_adrs  <= w_next;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_adrs  <= ZERO;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign adrsOut   = r_adrs;
    assign adrsValid = r_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_reg_adrs_sequencer.sv
// Directed bench for reg_adrs_sequencer (ADRS_WIDTH=3, ZERO_ADRS=0); expectations follow SKIP_ZERO_EN.
module tb_reg_adrs_sequencer;

    logic       CLK;
    logic       Reset;
    logic       start;
    logic [1:0] mode;
    logic [2:0] firstAdrs;
    logic [2:0] lastAdrs;
    logic       stall;
    logic [2:0] adrsOut;
    logic       adrsValid;
    logic       busy;
    logic       done;

    int n_vec = 0;
    int n_err = 0;

    reg_adrs_sequencer #(
        .ADRS_WIDTH (3),
        .ZERO_ADRS  (0)
    ) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .start     (start),
        .mode      (mode),
        .firstAdrs (firstAdrs),
        .lastAdrs  (lastAdrs),
        .stall     (stall),
        .adrsOut   (adrsOut),
        .adrsValid (adrsValid),
        .busy      (busy),
        .done      (done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [2:0] ea, input logic ev, input logic eb, input logic ed);
        n_vec++;
        assert ({adrsOut, adrsValid, busy, done} === {ea, ev, eb, ed})
        else begin
            n_err++;
            $error("FAIL %s: adrs/valid/busy/done = %0d/%0b/%0b/%0b, expected %0d/%0b/%0b/%0b",
                   tag, adrsOut, adrsValid, busy, done, ea, ev, eb, ed);
        end
    endtask

    task automatic step(input string tag, input logic [2:0] ea, input logic ev, input logic eb, input logic ed);
        @(posedge CLK);
        #1;
        chk(tag, ea, ev, eb, ed);
    endtask

    task automatic go(input logic [1:0] m, input logic [2:0] f, input logic [2:0] l);
        start     = 1'b1;
        mode      = m;
        firstAdrs = f;
        lastAdrs  = l;
    endtask

    initial begin
        Reset = 1'b0; start = 1'b0; mode = 2'b00; firstAdrs = 3'd0; lastAdrs = 3'd0; stall = 1'b0;
        #1 Reset = 1'b1;
        #1 chk("reset", 3'd0, 1'b0, 1'b0, 1'b0);
        @(posedge CLK); #1 Reset = 1'b0;
        step("idle_after_reset", 3'd0, 1'b0, 1'b0, 1'b0);

        // UP 2..5
        go(2'b01, 3'd2, 3'd5);
        step("up_a0", 3'd2, 1'b1, 1'b1, 1'b0);
        start = 1'b0;
        step("up_a1", 3'd3, 1'b1, 1'b1, 1'b0);
        step("up_a2", 3'd4, 1'b1, 1'b1, 1'b0);
        step("up_a3", 3'd5, 1'b1, 1'b1, 1'b0);
        step("up_done", 3'd0, 1'b0, 1'b1, 1'b1);
        step("up_idle", 3'd0, 1'b0, 1'b0, 1'b0);

        // DOWN 1..6 with two stall cycles on the second address
        go(2'b10, 3'd1, 3'd6);
        step("dn_a0", 3'd1, 1'b1, 1'b1, 1'b0);
        start = 1'b0;
`ifdef SKIP_ZERO_EN
        step("dn_a1", 3'd7, 1'b1, 1'b1, 1'b0);
        stall = 1'b1;
        step("dn_stall0", 3'd7, 1'b1, 1'b1, 1'b0);
        step("dn_stall1", 3'd7, 1'b1, 1'b1, 1'b0);
        stall = 1'b0;
        step("dn_a2", 3'd6, 1'b1, 1'b1, 1'b0);
`else
        step("dn_a1", 3'd0, 1'b1, 1'b1, 1'b0);
        stall = 1'b1;
        step("dn_stall0", 3'd0, 1'b1, 1'b1, 1'b0);
        step("dn_stall1", 3'd0, 1'b1, 1'b1, 1'b0);
        stall = 1'b0;
        step("dn_a2", 3'd7, 1'b1, 1'b1, 1'b0);
        step("dn_a3", 3'd6, 1'b1, 1'b1, 1'b0);
`endif
        step("dn_done", 3'd0, 1'b0, 1'b1, 1'b1);
        step("dn_idle", 3'd0, 1'b0, 1'b0, 1'b0);

        // CONST ignores lastAdrs
        go(2'b00, 3'd5, 3'd2);
        step("const_a0", 3'd5, 1'b1, 1'b1, 1'b0);
        start = 1'b0;
        step("const_done", 3'd0, 1'b0, 1'b1, 1'b1);
        step("const_idle", 3'd0, 1'b0, 1'b0, 1'b0);

        // Reserved mode behaves as CONST
        go(2'b11, 3'd3, 3'd6);
        step("rsv_a0", 3'd3, 1'b1, 1'b1, 1'b0);
        start = 1'b0;
        step("rsv_done", 3'd0, 1'b0, 1'b1, 1'b1);
        step("rsv_idle", 3'd0, 1'b0, 1'b0, 1'b0);

        // start held through RUN and DONE with changed inputs: no second sequence
        go(2'b01, 3'd1, 3'd3);
        step("restart_a0", 3'd1, 1'b1, 1'b1, 1'b0);
        firstAdrs = 3'd7; lastAdrs = 3'd7; mode = 2'b10;
        step("restart_a1", 3'd2, 1'b1, 1'b1, 1'b0);
        step("restart_a2", 3'd3, 1'b1, 1'b1, 1'b0);
        step("restart_done", 3'd0, 1'b0, 1'b1, 1'b1);
        step("restart_leave_done", 3'd0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        step("restart_idle", 3'd0, 1'b0, 1'b0, 1'b0);

        // first == last
        go(2'b01, 3'd4, 3'd4);
        step("single_a0", 3'd4, 1'b1, 1'b1, 1'b0);
        start = 1'b0;
        step("single_done", 3'd0, 1'b0, 1'b1, 1'b1);
        step("single_idle", 3'd0, 1'b0, 1'b0, 1'b0);

        // UP starting at the zero register
        go(2'b01, 3'd0, 3'd3);
`ifdef SKIP_ZERO_EN
        step("z0_a0", 3'd1, 1'b1, 1'b1, 1'b0);
        start = 1'b0;
`else
        step("z0_a0", 3'd0, 1'b1, 1'b1, 1'b0);
        start = 1'b0;
        step("z0_a1", 3'd1, 1'b1, 1'b1, 1'b0);
`endif
        step("z0_a2", 3'd2, 1'b1, 1'b1, 1'b0);
        step("z0_a3", 3'd3, 1'b1, 1'b1, 1'b0);
        step("z0_done", 3'd0, 1'b0, 1'b1, 1'b1);
        step("z0_idle", 3'd0, 1'b0, 1'b0, 1'b0);

        // UP ending at the zero register, wrapping through 7
        go(2'b01, 3'd6, 3'd0);
        step("zl_a0", 3'd6, 1'b1, 1'b1, 1'b0);
        start = 1'b0;
        step("zl_a1", 3'd7, 1'b1, 1'b1, 1'b0);
`ifndef SKIP_ZERO_EN
        step("zl_a2", 3'd0, 1'b1, 1'b1, 1'b0);
`endif
        step("zl_done", 3'd0, 1'b0, 1'b1, 1'b1);
        step("zl_idle", 3'd0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of an UP sweep
        go(2'b01, 3'd2, 3'd6);
        step("rst_a0", 3'd2, 1'b1, 1'b1, 1'b0);
        start = 1'b0;
        step("rst_a1", 3'd3, 1'b1, 1'b1, 1'b0);
        step("rst_a2", 3'd4, 1'b1, 1'b1, 1'b0);
        #2 Reset = 1'b1;
        #1 chk("rst_async", 3'd0, 1'b0, 1'b0, 1'b0);
        @(posedge CLK); #1 Reset = 1'b0;
        step("rst_idle0", 3'd0, 1'b0, 1'b0, 1'b0);
        step("rst_idle1", 3'd0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
